// File: rtl/internal_framebuffer_scissor_memset.sv
// Clear engine for the internal framebuffer RAM: fills the scissor rectangle (or the whole
// screen) with the clear colour, one RAM word of NUMBER_OF_PIXELS_PER_BEAT pixels per cycle.
module internal_framebuffer_scissor_memset #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT    = 4,
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int X_BIT_WIDTH                  = 11,
    parameter int Y_BIT_WIDTH                  = 11,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18
) (
    input  logic                                                                  clk,
    input  logic                                                                  reset,
    input  logic [NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH-1:0]                       confClearColor,
    input  logic                                                                  confEnableScissor,
    input  logic [X_BIT_WIDTH-1:0]                                                confScissorStartX,
    input  logic [Y_BIT_WIDTH-1:0]                                                confScissorStartY,
    input  logic [X_BIT_WIDTH-1:0]                                                confScissorEndX,
    input  logic [Y_BIT_WIDTH-1:0]                                                confScissorEndY,
    input  logic [X_BIT_WIDTH-1:0]                                                confXResolution,
    input  logic [Y_BIT_WIDTH-1:0]                                                confYResolution,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0]                                       confMask,
    input  logic                                                                  apply,
    output logic                                                                  applied,
    output logic [NUMBER_OF_PIXELS_PER_BEAT*NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH-1:0] writeDataPort,
    output logic                                                                  writeEnablePort,
    output logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG-$clog2(NUMBER_OF_PIXELS_PER_BEAT)-1:0] writeAddrPort,
    output logic [NUMBER_OF_PIXELS_PER_BEAT*NUMBER_OF_SUB_PIXELS-1:0]             writeMaskPort
);
    localparam int PPB            = NUMBER_OF_PIXELS_PER_BEAT;
    localparam int NSP            = NUMBER_OF_SUB_PIXELS;
    localparam int PPB_LG         = $clog2(PPB);
    localparam int XW             = X_BIT_WIDTH;
    localparam int YW             = Y_BIT_WIDTH;
    localparam int MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - PPB_LG;
    localparam int MEM_WIDTH      = PPB * NSP * SUB_PIXEL_WIDTH;
    localparam int MASK_WIDTH     = PPB * NSP;

    typedef enum logic [1:0] {IDLE, SETUP, FILL} state_t;

    state_t                    state_q, state_d;
    logic                      applied_q, applied_d;
    logic                      we_q, we_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MASK_WIDTH-1:0]     mask_q, mask_d;
    logic [MEM_WIDTH-1:0]      data_q, data_d;
    logic [NSP-1:0]            conf_mask_q, conf_mask_d;
    logic [XW-1:0]             xs_q, xs_d, xe_q, xe_d, xres_q, xres_d;
    logic [YW-1:0]             ys_q, ys_d, ye_q, ye_d;
    logic [XW-1:0]             stride_q, stride_d, bx0_q, bx0_d, bx1_q, bx1_d, bx_q, bx_d;
    logic [YW-1:0]             y_q, y_d;
    logic [MEM_ADDR_WIDTH-1:0] row_base_q, row_base_d;

    logic [XW-1:0]             xs_in, xe_in, xs_clip, xe_clip;
    logic [YW-1:0]             ys_in, ye_in, ys_clip, ye_clip;
    logic [XW-1:0]             setup_stride;
    logic [XW+YW-1:0]          row_prod;
    logic                      rect_empty;
    logic                      last_row;
    logic                      load_beat;
    logic                      next_row;
    logic [XW-1:0]             nbx;
    logic [MEM_ADDR_WIDTH-1:0] nrow;
    logic [MASK_WIDTH-1:0]     pix_mask;

    // Clip against the live inputs so only already-clipped bounds are latched.
    always_comb begin
        xs_in   = confEnableScissor ? confScissorStartX : '0;
        xe_in   = confEnableScissor ? confScissorEndX   : confXResolution;
        ys_in   = confEnableScissor ? confScissorStartY : '0;
        ye_in   = confEnableScissor ? confScissorEndY   : confYResolution;
        xs_clip = (xs_in < confXResolution) ? xs_in : confXResolution;
        xe_clip = (xe_in < confXResolution) ? xe_in : confXResolution;
        ys_clip = (ys_in < confYResolution) ? ys_in : confYResolution;
        ye_clip = (ye_in < confYResolution) ? ye_in : confYResolution;
    end

    assign setup_stride = xres_q >> PPB_LG;
    assign row_prod     = {{XW{1'b0}}, ys_q} * {{YW{1'b0}}, setup_stride};
    assign rect_empty   = (xs_q >= xe_q) || (ys_q >= ye_q);
    assign last_row     = (({1'b0, y_q} + (YW+1)'(1)) == {1'b0, ye_q});

    // Selects the beat that the output registers will present after this edge.
    always_comb begin
        load_beat = 1'b0;
        next_row  = 1'b0;
        nbx       = bx_q;
        nrow      = row_base_q;
        case (state_q)
            SETUP: begin
                if (!rect_empty) begin
                    load_beat = 1'b1;
                    nbx       = xs_q >> PPB_LG;
                    nrow      = MEM_ADDR_WIDTH'(row_prod);
                end
            end
            FILL: begin
                if (bx_q == bx1_q) begin
                    if (!last_row) begin
                        load_beat = 1'b1;
                        next_row  = 1'b1;
                        nbx       = bx0_q;
                        nrow      = row_base_q + MEM_ADDR_WIDTH'(stride_q);
                    end
                end else begin
                    load_beat = 1'b1;
                    nbx       = bx_q + XW'(1);
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < PPB; gi++) begin : g_pix
            logic [XW:0] px;
            logic        pix_en;
            assign px     = ({1'b0, nbx} << PPB_LG) + (XW+1)'(gi);
            assign pix_en = (px >= {1'b0, xs_q}) && (px < {1'b0, xe_q});
            assign pix_mask[gi*NSP +: NSP] = pix_en ? conf_mask_q : '0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        applied_d   = applied_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        mask_d      = mask_q;
        data_d      = data_q;
        conf_mask_d = conf_mask_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        xres_d      = xres_q;
        stride_d    = stride_q;
        bx0_d       = bx0_q;
        bx1_d       = bx1_q;
        bx_d        = bx_q;
        y_d         = y_q;
        row_base_d  = row_base_q;
        case (state_q)
            IDLE: begin
                if (apply) begin
                    state_d     = SETUP;
                    applied_d   = 1'b0;
                    data_d      = {PPB{confClearColor}};
                    conf_mask_d = confMask;
                    xs_d        = xs_clip;
                    xe_d        = xe_clip;
                    ys_d        = ys_clip;
                    ye_d        = ye_clip;
                    xres_d      = confXResolution;
                end
            end
            SETUP: begin
                stride_d = setup_stride;
                bx0_d    = xs_q >> PPB_LG;
                bx1_d    = (xe_q - XW'(1)) >> PPB_LG;
                y_d      = ys_q;
                if (rect_empty) begin
                    state_d   = IDLE;
                    applied_d = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!load_beat) begin
                    state_d   = IDLE;
                    applied_d = 1'b1;
                end
                if (next_row) begin
                    y_d = y_q + YW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                applied_d = 1'b1;
            end
        endcase
        if (load_beat) begin
            we_d       = 1'b1;
            addr_d     = nrow + MEM_ADDR_WIDTH'(nbx);
            mask_d     = pix_mask;
            bx_d       = nbx;
            row_base_d = nrow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            applied_q   <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            conf_mask_q <= '0;
            xs_q        <= '0;
            xe_q        <= '0;
            ys_q        <= '0;
            ye_q        <= '0;
            xres_q      <= '0;
            stride_q    <= '0;
            bx0_q       <= '0;
            bx1_q       <= '0;
            bx_q        <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            applied_q   <= applied_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            conf_mask_q <= conf_mask_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            xres_q      <= xres_d;
            stride_q    <= stride_d;
            bx0_q       <= bx0_d;
            bx1_q       <= bx1_d;
            bx_q        <= bx_d;
            y_q         <= y_d;
            row_base_q  <= row_base_d;
        end
    end

    assign applied         = applied_q;
    assign writeEnablePort = we_q;
    assign writeAddrPort   = addr_q;
    assign writeMaskPort   = mask_q;
    assign writeDataPort   = data_q;

endmodule

// File: tb/tb_internal_framebuffer_scissor_memset.sv
// Bench for the scissor clear engine: table of clear commands checked through a write
// scoreboard built from a pixel-level model, plus hand sequences for re-apply and reset.
module tb_internal_framebuffer_scissor_memset;
    localparam int PPB = 4, NSP = 4, SPW = 8, XW = 11, YW = 11, FBLG = 18;
    localparam int AW = FBLG - 2, MW = PPB * NSP * SPW, KW = PPB * NSP;
    localparam int XRES = 16, YRES = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NSP*SPW-1:0] confClearColor;
    logic              confEnableScissor;
    logic [XW-1:0]     confScissorStartX, confScissorEndX, confXResolution;
    logic [YW-1:0]     confScissorStartY, confScissorEndY, confYResolution;
    logic [NSP-1:0]    confMask;
    logic              apply;
    logic              applied;
    logic [MW-1:0]     writeDataPort;
    logic              writeEnablePort;
    logic [AW-1:0]     writeAddrPort;
    logic [KW-1:0]     writeMaskPort;

    always #5 clk = ~clk;

    internal_framebuffer_scissor_memset #(
        .NUMBER_OF_PIXELS_PER_BEAT(PPB), .NUMBER_OF_SUB_PIXELS(NSP), .SUB_PIXEL_WIDTH(SPW),
        .X_BIT_WIDTH(XW), .Y_BIT_WIDTH(YW), .FRAMEBUFFER_SIZE_IN_PIXEL_LG(FBLG)
    ) dut (
        .clk(clk), .reset(reset),
        .confClearColor(confClearColor), .confEnableScissor(confEnableScissor),
        .confScissorStartX(confScissorStartX), .confScissorStartY(confScissorStartY),
        .confScissorEndX(confScissorEndX), .confScissorEndY(confScissorEndY),
        .confXResolution(confXResolution), .confYResolution(confYResolution),
        .confMask(confMask), .apply(apply), .applied(applied),
        .writeDataPort(writeDataPort), .writeEnablePort(writeEnablePort),
        .writeAddrPort(writeAddrPort), .writeMaskPort(writeMaskPort)
    );

    typedef struct {
        bit          en;
        int          sx, ex, sy, ey;
        logic [3:0]  cmask;
        logic [31:0] color;
        int          exp_writes;
        int          exp_low;
        int          exp_last;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [KW-1:0] mask;
        logic [MW-1:0] data;
    } beat_t;

    beat_t         sb[$];
    logic [AW-1:0] cap_addr[$];
    logic [KW-1:0] cap_mask[$];
    int            total = 0;
    int            bad = 0;
    int            writes_seen = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every write beat seen by the RAM port must match the next expected beat.
    always @(negedge clk) begin
        if (writeEnablePort === 1'b1) begin
            beat_t e;
            writes_seen++;
            last_addr = writeAddrPort;
            cap_addr.push_back(writeAddrPort);
            cap_mask.push_back(writeMaskPort);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual_addr=%0h required=no_write", writeAddrPort);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", writeAddrPort, e.addr);
                chk("wr_mask", writeMaskPort, e.mask);
                chk("wr_data", writeDataPort, e.data);
            end
        end
    end

    function automatic void push_beat(input int y, input int bx, input logic [KW-1:0] m,
                                      input logic [31:0] color);
        beat_t b;
        b.addr = AW'(y * (XRES / PPB) + bx);
        b.mask = m;
        b.data = {PPB{color}};
        sb.push_back(b);
    endfunction

    // Pixel-level model: walk every covered pixel, close a beat when the word changes.
    function automatic void push_exp(input vec_t v);
        int xs, xe, ys, ye, cur, b;
        logic [KW-1:0] m;
        xs = v.en ? v.sx : 0;
        xe = v.en ? v.ex : XRES;
        ys = v.en ? v.sy : 0;
        ye = v.en ? v.ey : YRES;
        if (xs > XRES) xs = XRES;
        if (xe > XRES) xe = XRES;
        if (ys > YRES) ys = YRES;
        if (ye > YRES) ye = YRES;
        if (xs >= xe || ys >= ye) return;
        for (int y = ys; y < ye; y++) begin
            cur = -1;
            m = '0;
            for (int px = xs; px < xe; px++) begin
                b = px / PPB;
                if (b != cur) begin
                    if (cur >= 0) push_beat(y, cur, m, v.color);
                    cur = b;
                    m = '0;
                end
                m[(px % PPB) * NSP +: NSP] = v.cmask;
            end
            push_beat(y, cur, m, v.color);
        end
    endfunction

    task automatic drive(input vec_t v);
        confEnableScissor = v.en;
        confScissorStartX = XW'(v.sx);
        confScissorEndX   = XW'(v.ex);
        confScissorStartY = YW'(v.sy);
        confScissorEndY   = YW'(v.ey);
        confXResolution   = XW'(XRES);
        confYResolution   = YW'(YRES);
        confMask          = v.cmask;
        confClearColor    = v.color;
    endtask

    task automatic run_vec(input int idx, input vec_t v, input bit disturb);
        int low = 0;
        bit done = 0;
        push_exp(v);
        writes_seen = 0;
        @(negedge clk);
        drive(v);
        apply = 1'b1;
        @(posedge clk);
        #1 apply = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (applied === 1'b1) done = 1;
            else begin
                low++;
                if (disturb && low == 3) begin
                    apply = 1'b1;
                    confEnableScissor = 1'b0;
                    confScissorEndX = XW'(16);
                    confScissorStartY = '0;
                    confMask = 4'h3;
                    confClearColor = ~confClearColor;
                end
                if (disturb && low == 5) apply = 1'b0;
            end
        end
        chk("applied_return", done, 1'b1);
        @(negedge clk);
        chk("applied_low", low, v.exp_low);
        chk("write_count", writes_seen, v.exp_writes);
        chk("sb_left", sb.size(), 0);
        chk("we_idle", writeEnablePort, 1'b0);
        if (v.exp_writes > 0) chk("last_addr", last_addr, v.exp_last);
        sb.delete();
        $display("cmd %0d: scissor=%0d x=%0d..%0d y=%0d..%0d writes=%0d applied_low=%0d",
                 idx, v.en, v.sx, v.ex, v.sy, v.ey, writes_seen, low);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [AW-1:0] hand_addr[6];
        logic [KW-1:0] hand_mask[6];
        int c;

        hand_addr = '{16'd4, 16'd5, 16'd6, 16'd8, 16'd9, 16'd10};
        hand_mask = '{16'hF000, 16'hFFFF, 16'h000F, 16'hF000, 16'hFFFF, 16'h000F};
        tbl[0] = '{1, 3, 9, 1, 3, 4'hF, 32'h11223344, 6, 7, 10};
        tbl[1] = '{0, 3, 9, 1, 3, 4'hF, 32'hA5A55A5A, 16, 17, 15};
        tbl[2] = '{1, 5, 5, 1, 3, 4'hF, 32'hDEADBEEF, 0, 1, 0};
        tbl[3] = '{1, 0, 40, 0, 9, 4'b0101, 32'hCAFEF00D, 16, 17, 15};
        tbl[4] = '{1, 2, 3, 3, 4, 4'hF, 32'h01020304, 1, 2, 12};
        tbl[5] = '{1, 0, 16, 3, 2, 4'hF, 32'h55667788, 0, 1, 0};

        reset = 1'b1;
        apply = 1'b0;
        drive(tbl[0]);
        repeat (3) @(negedge clk);
        chk("rst_applied", applied, 1'b1);
        chk("rst_we", writeEnablePort, 1'b0);
        chk("rst_addr", writeAddrPort, '0);
        chk("rst_mask", writeMaskPort, '0);
        chk("rst_data", writeDataPort, '0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, tbl[i], 0);

        // Re-apply and config change while filling: must not disturb the running clear.
        cap_addr.delete();
        cap_mask.delete();
        run_vec(6, tbl[0], 1);
        chk("hand_count", cap_addr.size(), 6);
        for (int k = 0; k < 6 && k < cap_addr.size(); k++) begin
            chk("hand_addr", cap_addr[k], hand_addr[k]);
            chk("hand_mask", cap_mask[k], hand_mask[k]);
        end

        // Reset during the third fill beat aborts the command.
        push_exp(tbl[0]);
        writes_seen = 0;
        @(negedge clk);
        drive(tbl[0]);
        apply = 1'b1;
        @(posedge clk);
        #1 apply = 1'b0;
        c = 0;
        while (writes_seen < 3 && c < 20) begin
            @(negedge clk);
            #1 c++;
        end
        chk("abort_reached_beat3", writes_seen, 3);
        reset = 1'b1;
        #1;
        chk("abort_we", writeEnablePort, 1'b0);
        chk("abort_applied", applied, 1'b1);
        chk("abort_sb_left", sb.size(), 3);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_more_writes", writes_seen, 3);
        $display("cmd 7: reset on third beat, writes=%0d", writes_seen);

        cap_addr.delete();
        cap_mask.delete();
        run_vec(8, tbl[0], 0);
        chk("after_reset_first_addr", (cap_addr.size() > 0) ? cap_addr[0] : '1, 16'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
